// File: rtl/order_pkg.sv
// rtl/order_pkg.sv - order word layout and slot types shared by the queue, generator and display
package order_pkg;

  localparam int ORDER_W = 24;
  localparam int TIME_W  = 6;

  // {dish0[4:0], opt0[6:0], dish1[4:0], opt1[6:0]}
  localparam int DISH0_LSB = 19;
  localparam int OPT0_LSB  = 12;
  localparam int DISH1_LSB = 7;
  localparam int OPT1_LSB  = 0;

  typedef logic [ORDER_W-1:0] order_t;

  typedef struct packed {
    logic              valid;
    order_t            order;
    logic [TIME_W-1:0] timer;
    logic              pend_exp;
  } slot_t;

  localparam order_t EMPTY_ORDER = '0;

  function automatic logic [4:0] dish0(input order_t o);
    return o[DISH0_LSB +: 5];
  endfunction

  function automatic logic [6:0] opt0(input order_t o);
    return o[OPT0_LSB +: 7];
  endfunction

  function automatic logic [4:0] dish1(input order_t o);
    return o[DISH1_LSB +: 5];
  endfunction

  function automatic logic [6:0] opt1(input order_t o);
    return o[OPT1_LSB +: 7];
  endfunction

endpackage

// File: rtl/order_queue_if.sv
// rtl/order_queue_if.sv - order push and dish serve handshakes between game logic and the queue
interface order_queue_if;
  import order_pkg::*;

  logic   new_valid;
  order_t new_order;
  logic   new_ready;
  logic   serve_valid;
  order_t serve_dish;
  logic   serve_ack;
  logic   serve_hit;

  modport master (
    output new_valid, new_order, serve_valid, serve_dish,
    input  new_ready, serve_ack, serve_hit
  );

  modport slave (
    input  new_valid, new_order, serve_valid, serve_dish,
    output new_ready, serve_ack, serve_hit
  );

endinterface

// File: rtl/order_match.sv
// rtl/order_match.sv - DEPTH-way dish comparator and lowest-index pickers for serve and expiry
module order_match
  import order_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] pend_exp,
  input  order_t           orders [DEPTH],
  input  order_t           key,
  output logic             serve_hit,
  output logic [IDX_W-1:0] serve_idx,
  output logic             exp_hit,
  output logic [IDX_W-1:0] exp_idx
);

  logic [DEPTH-1:0] serve_req;
  logic [DEPTH-1:0] exp_req;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      serve_req[i] = valid[i] && !pend_exp[i] && (orders[i] == key);
    end
    exp_req = valid & pend_exp;
  end

  // scan downwards so the lowest (oldest) requesting slot is the one left standing
  always_comb begin
    serve_hit = 1'b0;
    serve_idx = '0;
    exp_hit   = 1'b0;
    exp_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (serve_req[i]) begin
        serve_hit = 1'b1;
        serve_idx = IDX_W'(i);
      end
      if (exp_req[i]) begin
        exp_hit = 1'b1;
        exp_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/order_queue.sv
// rtl/order_queue.sv - compacting queue of active orders with countdown timers, serve matching and expiry
module order_queue
  import order_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter int  TIMEOUT = 30,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  order_queue_if.slave      q,
  output logic              expire_pulse,
  output logic [CNT_W-1:0]  count,
  output order_t            head_order,
  output logic [TIME_W-1:0] head_time,
  output logic [7:0]        served_cnt,
  output logic [7:0]        expired_cnt
);

  slot_t            slots   [DEPTH];
  slot_t            shifted [DEPTH];
  slot_t            nxt     [DEPTH];
  order_t           orders  [DEPTH];
  logic [DEPTH-1:0] valid_v;
  logic [DEPTH-1:0] pend_v;
  logic             match_hit, exp_hit;
  logic [IDX_W-1:0] match_idx, exp_idx, rm_idx;
  logic             ready, hit, remove, push;
  logic [CNT_W-1:0] push_pos;
  slot_t            new_slot;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_v[i] = slots[i].valid;
      pend_v[i]  = slots[i].pend_exp;
      orders[i]  = slots[i].order;
    end
  end

  order_match #(.DEPTH(DEPTH)) u_match (
    .valid     (valid_v),
    .pend_exp  (pend_v),
    .orders    (orders),
    .key       (q.serve_dish),
    .serve_hit (match_hit),
    .serve_idx (match_idx),
    .exp_hit   (exp_hit),
    .exp_idx   (exp_idx)
  );

  // a serve hit owns the single removal slot; a pending expiry waits a cycle
  assign hit         = q.serve_valid && match_hit;
  assign remove      = hit || exp_hit;
  assign rm_idx      = hit ? match_idx : exp_idx;
  assign ready       = (count != CNT_W'(DEPTH));
  assign q.new_ready = ready;
  assign push        = q.new_valid && ready && (q.new_order != EMPTY_ORDER);
  assign push_pos    = count - CNT_W'(remove);
  assign new_slot    = '{valid: 1'b1, order: q.new_order, timer: TIME_W'(TIMEOUT), pend_exp: 1'b0};

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = slots[i + 1];
    end
    shifted[DEPTH - 1] = '0;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_t s;
      s = (remove && (IDX_W'(i) >= rm_idx)) ? shifted[i] : slots[i];
      if (tick && s.valid && (s.timer != '0)) begin
        s.timer = s.timer - TIME_W'(1);
        if (s.timer == '0) s.pend_exp = 1'b1;
      end
      // the new order lands after the shift and after this cycle's tick
      if (push && (CNT_W'(i) == push_pos)) s = new_slot;
      nxt[i] = s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      count        <= '0;
      q.serve_ack  <= 1'b0;
      q.serve_hit  <= 1'b0;
      expire_pulse <= 1'b0;
      served_cnt   <= '0;
      expired_cnt  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= nxt[i];
      count        <= count + CNT_W'(push) - CNT_W'(remove);
      q.serve_ack  <= q.serve_valid;
      q.serve_hit  <= hit;
      expire_pulse <= exp_hit && !hit;
      if (hit && (served_cnt != 8'hFF)) served_cnt <= served_cnt + 8'd1;
      if (exp_hit && !hit && (expired_cnt != 8'hFF)) expired_cnt <= expired_cnt + 8'd1;
    end
  end

  assign head_order = slots[0].valid ? slots[0].order : EMPTY_ORDER;
  assign head_time  = slots[0].valid ? slots[0].timer : '0;

endmodule
